// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: state encoding and counter sizing.
package spi_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BIT_CNT_W      = $clog2(DATA_WIDTH_DEF + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HIGH,
        SCK_LOW,
        HOLD,
        DONE
    } spi_state_e;

    // Bit-counter width for an arbitrary word size (must hold the value n).
    function automatic int bit_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// System-side request/response bundle of the SPI master.
interface spi_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;

    // master: the requesting control logic; slave: the spi_master block itself.
    modport master (output start, output tx_data, input rx_data, input busy, input done);
    modport slave  (input start, input tx_data, output rx_data, output busy, output done);
endinterface

// File: rtl/spi_master_clk_tick.sv
// Half-period timer: reloads with CLK_DIV-1 and pulses tick each time it expires.
module spi_clk_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (SCLK idle low), MSB first, one full-duplex word per start.
// Build option SPI_MASTER_LOOPBACK_EN: capture MOSI instead of the MISO pin (self-test).
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CLK_DIV    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    spi_master_if.slave  bus,
    output logic         SCLK,
    output logic         CS,
    output logic         MOSI,
    input  logic         MISO
);
    localparam int BCW = bit_cnt_w(DATA_WIDTH);

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  tick;
    logic                  tick_en;
    logic                  cap_bit;
    logic [DATA_WIDTH-1:0] tx_next;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = MISO;
    // mosi_q still holds the bit on the wire when SCLK falls, so rx mirrors tx.
    assign cap_bit = mosi_q;
`else
    assign cap_bit = MISO;
`endif

    assign tick_en = (state_q != IDLE) && (state_q != DONE);
    assign tx_next = tx_shift_q << 1;

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .en      (tick_en),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        accept     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_d    = SETUP;
                    tx_shift_d = bus.tx_data;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    cs_d       = 1'b0;
                    mosi_d     = bus.tx_data[DATA_WIDTH-1];
                    busy_d     = 1'b1;
                end
            end
            SETUP, SCK_LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SCK_HIGH;
                end
            end
            SCK_HIGH: begin
                if (tick) begin
                    sclk_d     = 1'b0;
                    rx_shift_d = (rx_shift_q << 1) | DATA_WIDTH'(cap_bit);
                    bit_cnt_d  = bit_cnt_q + BCW'(1);
                    // Last bit keeps MOSI stable through HOLD.
                    if (bit_cnt_q < BCW'(DATA_WIDTH - 1)) begin
                        tx_shift_d = tx_next;
                        mosi_d     = tx_next[DATA_WIDTH-1];
                        state_d    = SCK_LOW;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = DONE;
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    mosi_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SCLK        = sclk_q;
    assign CS          = cs_q;
    assign MOSI        = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DATA_WIDTH=8, CLK_DIV=2) with a behavioural SPI slave.
module tb_spi_master;
    logic clk;
    logic reset_n;
    logic sclk, cs, mosi, miso;

    spi_master_if #(.DATA_WIDTH(8)) bus ();

    spi_master #(
        .DATA_WIDTH (8),
        .CLK_DIV    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .SCLK    (sclk),
        .CS      (cs),
        .MOSI    (mosi),
        .MISO    (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave: launches on CS fall / SCLK fall, samples MOSI on SCLK rise.
    logic [7:0] slave_tx = 8'h00;
    logic [7:0] slv_sh   = 8'h00;
    logic [7:0] slave_rx = 8'h00;
    logic       force_miso0 = 1'b0;
    int         rises = 0;

    always @(negedge cs) slv_sh = slave_tx;
    always @(negedge sclk) if (cs === 1'b0) slv_sh = slv_sh << 1;
    always @(posedge sclk) begin
        rises = rises + 1;
        if (cs === 1'b0) slave_rx = {slave_rx[6:0], mosi};
    end
    // Idle value 1 so any capture outside CS-low would corrupt rx_data.
    assign miso = force_miso0 ? 1'b0 : (cs ? 1'b1 : slv_sh[7]);

    int checks = 0;
    int errors = 0;
    int rise_base = 0;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] stx;
        logic [7:0] exp_slave;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rx_expect(input logic [7:0] exp_slave, input logic [7:0] exp_rx);
`ifdef SPI_MASTER_LOOPBACK_EN
        return exp_slave;
`else
        return exp_rx;
`endif
    endfunction

    task automatic issue(input logic [7:0] tx, input logic [7:0] stx);
        @(negedge clk);
        slave_tx    = stx;
        bus.tx_data = tx;
        bus.start   = 1'b1;
        rise_base   = rises;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called in cycle 1 after acceptance; returns at the done cycle (or on timeout).
    task automatic finish_xfer(input string name, input logic [7:0] tx,
                               input logic [7:0] exp_slave, input logic [7:0] exp_rx);
        int done_t;
        int cs_low;
        int first_rise;
        check({name, " cs_c1"}, cs, 0);
        check({name, " busy_c1"}, bus.busy, 1);
        check({name, " mosi_c1"}, mosi, tx[7]);
        done_t = -1;
        cs_low = 0;
        first_rise = -1;
        for (int n = 1; n <= 200; n++) begin
            if (cs === 1'b0) cs_low++;
            if (sclk === 1'b1 && first_rise < 0) first_rise = n;
            if (bus.done === 1'b1) begin
                done_t = n;
                break;
            end
            @(negedge clk);
        end
        check({name, " done_t"}, done_t, 35);
        check({name, " cs_low"}, cs_low, 34);
        check({name, " first_rise"}, first_rise, 3);
        check({name, " pulses"}, rises - rise_base, 8);
        check({name, " rx_data"}, bus.rx_data, rx_expect(exp_slave, exp_rx));
        check({name, " slave_rx"}, slave_rx, exp_slave);
        check({name, " busy_done"}, bus.busy, 0);
        check({name, " cs_done"}, cs, 1);
        check({name, " mosi_done"}, mosi, 0);
    endtask

    initial begin
        int hits;
        vecs[0] = '{tx: 8'hA5, stx: 8'h3C, exp_slave: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'h01, stx: 8'h80, exp_slave: 8'h01, exp_rx: 8'h80};
        vecs[2] = '{tx: 8'h80, stx: 8'h01, exp_slave: 8'h80, exp_rx: 8'h01};
        vecs[3] = '{tx: 8'h00, stx: 8'hFF, exp_slave: 8'h00, exp_rx: 8'hFF};
        vecs[4] = '{tx: 8'h6D, stx: 8'hB2, exp_slave: 8'h6D, exp_rx: 8'hB2};

        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst cs", cs, 1);
        check("rst sclk", sclk, 0);
        reset_n = 1'b1;

        // Idle with no start: every output holds its reset value.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle cs", cs, 1);
            check("idle sclk", sclk, 0);
            check("idle mosi", mosi, 0);
            check("idle busy", bus.busy, 0);
            check("idle done", bus.done, 0);
            check("idle rx", bus.rx_data, 0);
        end

        foreach (vecs[i]) begin
            issue(vecs[i].tx, vecs[i].stx);
            finish_xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].exp_slave, vecs[i].exp_rx);
            repeat (2) @(negedge clk);
        end

        // Back-to-back: second start in the IDLE cycle right after done.
        issue(8'hFF, 8'h81);
        finish_xfer("b2b_a", 8'hFF, 8'hFF, 8'h81);
        @(negedge clk);
        check("b2b gap_cs", cs, 1);
        slave_tx    = 8'hE7;
        bus.tx_data = 8'h00;
        bus.start   = 1'b1;
        rise_base   = rises;
        @(negedge clk);
        bus.start = 1'b0;
        finish_xfer("b2b_b", 8'h00, 8'h00, 8'hE7);
        repeat (2) @(negedge clk);

        // start held through the transfer and tx_data changed after acceptance.
        @(negedge clk);
        slave_tx    = 8'h66;
        bus.tx_data = 8'h5A;
        bus.start   = 1'b1;
        rise_base   = rises;
        @(negedge clk);
        bus.tx_data = 8'h11;
        finish_xfer("held", 8'h5A, 8'h5A, 8'h66);
        bus.start = 1'b0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cs === 1'b0 || bus.done === 1'b1) hits++;
        end
        check("held no_requeue", hits, 0);

        // Reset after the 3rd SCLK rise aborts the transfer at once.
        issue(8'h77, 8'h12);
        hits = 0;
        for (int i = 0; i < 100 && (rises - rise_base) < 3; i++) @(negedge clk);
        check("abort reached_rise3", rises - rise_base, 3);
        check("abort sclk_high", sclk, 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort cs", cs, 1);
        check("abort sclk", sclk, 0);
        check("abort busy", bus.busy, 0);
        check("abort mosi", mosi, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || cs === 1'b0) hits++;
        end
        check("abort no_done", hits, 0);
        check("abort rx_cleared", bus.rx_data, 0);
        issue(8'hC3, 8'hA5);
        finish_xfer("after_abort", 8'hC3, 8'hC3, 8'hA5);
        repeat (2) @(negedge clk);

        // MISO pin tied low: only loopback builds see the transmitted word.
        force_miso0 = 1'b1;
        issue(8'h96, 8'hFF);
        finish_xfer("miso0", 8'h96, 8'h96, 8'h00);
        force_miso0 = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
Single-channel SPI master that drives SCLK, CS and MOSI into the existing SPI slave and captures the slave's MISO reply. It sits between the system-side register/control logic and the SPI pins. Each accepted start issues one full-duplex transfer of DATA_WIDTH bits, MSB first, with SCLK idle low.
- Launch: MOSI changes at CS assertion and on SCLK falling edges.
- Slave sampling: the slave samples MOSI on rising edges.
- Capture: the master captures MISO on falling edges.

Parameters:
DATA_WIDTH, 8, bits per transfer; must match the slave.
CLK_DIV, 2, SCLK half-period in clk cycles; legal values are 1 and above.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  transfer request; sampled only in IDLE.
tx_data  input  DATA_WIDTH  word to send; latched on the accepted start cycle.
rx_data  output  DATA_WIDTH  last word received; updated when done is asserted.
busy  output  1  high from the cycle after an accepted start until done is asserted.
done  output  1  one-cycle pulse at transfer end.
SCLK  output  1  SPI clock; idle 0.
CS  output  1  chip select, active-low; idle 1.
MOSI  output  1  serial data to the slave.
MISO  input  1  serial data from the slave; high-Z while CS=1, ignored outside transfers.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: CS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0.
  - Internal state: shift registers and counters cleared; state=IDLE.
  - Reset in mid-transfer aborts it immediately, with no done pulse.
- States: IDLE, SETUP, SCK_HIGH, SCK_LOW, HOLD, DONE.
- IDLE:
  - On start=1, latch tx_data into tx_shift and go to SETUP.
  - On entry to SETUP: CS=0, MOSI=tx_data[MSB], busy=1, bit counter=0.
- SETUP: holds for CLK_DIV cycles, then SCLK rises and the state goes to SCK_HIGH.
- SCK_HIGH: lasts CLK_DIV cycles. At its end:
  - SCLK falls, MISO is shifted into the rx_shift LSB, and the bit counter increments.
  - If bit counter < DATA_WIDTH: tx_shift shifts left, MOSI = next bit, go to SCK_LOW.
  - Otherwise: go to HOLD with MOSI unchanged.
- SCK_LOW: lasts CLK_DIV cycles, then SCLK rises and the state returns to SCK_HIGH.
- HOLD: lasts CLK_DIV cycles with CS=0 and SCLK=0, then goes to DONE.
- DONE (one cycle):
  - CS=1, busy=0, done=1, rx_data=rx_shift, MOSI=0.
  - Next cycle returns to IDLE.
- Timing, with the start-sampling edge as t=0 and D=CLK_DIV:
  - CS falls at t=1.
  - k-th SCLK rise (k=1..DATA_WIDTH) at t=1+(2k-1)·D.
  - k-th fall at t=1+2k·D.
  - done and CS rise at t=1+(2·DATA_WIDTH+1)·D. For the defaults this is t=35.
- Exactly DATA_WIDTH SCLK pulses per transfer; never a partial pulse, except when reset aborts a transfer.
- start while busy or in DONE: ignored and not queued.
- start may be asserted in the cycle after done; it is accepted in IDLE, giving a minimum of one IDLE cycle with CS=1 between transfers.
- tx_data changes after acceptance do not affect the transfer in flight.
- MISO value while CS=1 (including Z/X) never reaches rx_shift.

Optional Feature:
SPI_MASTER_LOOPBACK_EN:
- Defined: the capture path samples MOSI instead of the MISO pin, so rx_data equals tx_data. Used for board/self-test. Pins still toggle normally.
- Undefined: MISO pin is captured as specified above.

Decomposition:
- Package spi_pkg holds:
  - DATA_WIDTH default constant.
  - State enumeration (IDLE, SETUP, SCK_HIGH, SCK_LOW, HOLD, DONE).
  - Bit-counter width constant, $clog2(DATA_WIDTH+1).
- One sub-module is natural: spi_clk_tick.
  - A down-counter that reloads with CLK_DIV-1 and emits a one-cycle tick on each half-period expiry.
  - Enabled only when not IDLE/DONE; cleared on entry to SETUP.
- The FSM in spi_master advances only on ticks.

Test Plan:
- Reset then idle, CLK_DIV=2, no start → CS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0 held for 50 cycles.
- Single transfer to slave:
  - Stimulus: tx_data=0xA5, slave slaveDataToSend=0x3C, start pulse.
  - Response: 8 SCLK pulses; slave slaveDataReceived=0xA5; done at t=35; rx_data=0x3C; CS low for exactly 34 cycles.
- Back-to-back transfers: start asserted on the cycle after done with tx_data 0xFF then 0x00 → second transfer starts; one CS-high gap cycle; slave receives 0xFF then 0x00.
- start held high during busy with tx_data changed to 0x11 mid-transfer → only one transfer per acceptance; slave receives the originally latched 0x5A.
- Reset mid-transfer: assert reset_n=0 after the 3rd SCLK rise → CS=1 and SCLK=0 asynchronously; no done; next transfer with 0xC3 completes correctly.
- With SPI_MASTER_LOOPBACK_EN defined and MISO forced to 0: tx_data=0x96 → rx_data=0x96. With the macro undefined, same stimulus → rx_data=0x00.
